ipsl_pcie_dma_cpld_tx_gen: RTL and testbench

Completer-side TLP generator for the EP DMA path. It accepts one memory-read request (MRd) at a time from the RX TLP receiver. It reads the requested payload from the BAR0 RAM read port and emits a single CplD TLP (3DW header plus payload) on the 128-bit AXIS slave interface toward the PCIe core. Requests it cannot serve get an unsupported-request completion instead.

---
 rtl/ipsl_pcie_dma_pkg.sv | 31 +++
 rtl/ipsl_pcie_dma_cpld_tx_gen_if.sv | 15 +
 rtl/ipsl_pcie_dma_cpld_realign.sv | 90 +++++++++
 rtl/ipsl_pcie_dma_cpld_tx_gen.sv | 148 ++++++++++++++
 tb/tb_ipsl_pcie_dma_cpld_tx_gen.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared TLP codes, completion status, FSM encoding and tkeep helper
// for the EP DMA completer path.
package ipsl_pcie_dma_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HDR,
        ST_DATA
    } cpld_state_e;

    // tkeep of the final beat, from the two LSBs of the DW length
    function automatic logic [3:0] last_keep(input logic [1:0] len_lsb);
        logic [1:0] r;
        r = len_lsb - 2'd1;
        unique case (r)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_cpld_tx_gen_if.sv
// 128-bit AXIS bus from the completion generator to the PCIe core.
// master: tvld/tdata/tkeep/tlast out, trdy in; slave: the reverse.
interface ipsl_pcie_dma_cpld_tx_gen_if;
    import ipsl_pcie_dma_pkg::*;

    logic         tvld;
    logic         trdy;
    logic [127:0] tdata;
    logic [3:0]   tkeep;
    logic         tlast;

    modport master (output tvld, tdata, tkeep, tlast, input trdy);
    modport slave  (input tvld, tdata, tkeep, tlast, output trdy);

endinterface

// File: rtl/ipsl_pcie_dma_cpld_realign.sv
// BAR0 line fetcher plus 2-line DW realigner for CplD payload.
// Ports: start/line/off/lines in; bar0 read port; out_vld/out_rdy/out_data.
module ipsl_pcie_dma_cpld_realign
    import ipsl_pcie_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_line,
    input  logic [1:0]            start_off,
    input  logic [7:0]            start_lines,
    output logic                  o_bar0_rd_clk_en,
    output logic [ADDR_WIDTH-1:0] o_bar0_rd_addr,
    input  logic [127:0]          i_bar0_rd_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [127:0]          out_data
);

    logic [7:0]            lines_left;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            off_q;
    logic                  pend;
    logic                  cur_vld;
    logic [127:0]          cur_q;
    logic [127:0]          prev_q;
    logic [127:0]          line;
    logic [255:0]          pair;
    logic                  cons;
    logic                  issue;

    // RAM data arriving this cycle is forwarded straight out, so a
    // steady stream needs no bubble; it is parked in cur_q on a stall.
    assign line    = pend ? i_bar0_rd_data : cur_q;
    assign out_vld = pend | cur_vld;
    assign cons    = out_vld & out_rdy;
    // A read is issued only when the current slot frees up this cycle.
    assign issue   = (lines_left != 8'd0) & (~out_vld | cons);

    assign o_bar0_rd_clk_en = issue;
    assign o_bar0_rd_addr   = rd_addr;

    // Beat n = DWs off+1 .. off+4 of {line n, line n-1}.
    assign pair = {line, prev_q};

    always_comb begin
        out_data = pair[255:128];
        unique case (off_q)
            2'd0: out_data = pair[159:32];
            2'd1: out_data = pair[191:64];
            2'd2: out_data = pair[223:96];
            2'd3: out_data = pair[255:128];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_left <= '0;
            rd_addr    <= '0;
            off_q      <= '0;
            pend       <= 1'b0;
            cur_vld    <= 1'b0;
            cur_q      <= '0;
            prev_q     <= '0;
        end else begin
            pend <= issue;
            if (start) begin
                lines_left <= start_lines;
                rd_addr    <= start_line;
                off_q      <= start_off;
                cur_vld    <= 1'b0;
            end else begin
                if (issue) begin
                    lines_left <= lines_left - 8'd1;
                    rd_addr    <= rd_addr + 1'b1;
                end
                if (cons) begin
                    prev_q  <= line;
                    cur_vld <= 1'b0;
                end else if (pend) begin
                    cur_q   <= i_bar0_rd_data;
                    cur_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ipsl_pcie_dma_cpld_tx_gen.sv
// Completer TLP generator: one MRd in, one CplD (or UR Cpl) out on AXIS.
// Ports: cfg id, MRd request handshake, BAR0 read port, axis_slave bus.
module ipsl_pcie_dma_cpld_tx_gen
    import ipsl_pcie_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_CPL_DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           i_cfg_cmplt_id,
    input  logic                  i_cpld_req_vld,
    output logic                  o_cpld_req_rdy,
    output logic                  o_cpld_tx_rdy,
    input  logic [2:0]            i_mrd_tc,
    input  logic [2:0]            i_mrd_attr,
    input  logic [9:0]            i_mrd_length,
    input  logic [15:0]           i_mrd_id,
    input  logic [7:0]            i_mrd_tag,
    input  logic [63:0]           i_mrd_addr,
    output logic                  o_bar0_rd_clk_en,
    output logic [ADDR_WIDTH-1:0] o_bar0_rd_addr,
    input  logic [127:0]          i_bar0_rd_data,
    ipsl_pcie_dma_cpld_tx_gen_if.master axis_slave
);

    cpld_state_e  state;
    logic [2:0]   tc_q;
    logic [2:0]   attr_q;
    logic [9:0]   len_q;
    logic [15:0]  rid_q;
    logic [7:0]   tag_q;
    logic [15:0]  cid_q;
    logic [4:0]   la_q;
    logic         ur_q;
    logic [7:0]   beats_q;

    logic         req_fire;
    logic         ur;
    logic [7:0]   nbeats;
    logic         active;
    logic         is_last;
    logic         beat_fire;
    logic         line_vld;
    logic         line_rdy;
    logic [127:0] line_data;
    logic [31:0]  dw0;
    logic [31:0]  dw1;
    logic [31:0]  dw2;
    logic [127:0] tdata;
    logic         unused_addr;

    assign unused_addr = ^{i_mrd_addr[63:ADDR_WIDTH+4], i_mrd_addr[1:0]};

    assign req_fire = i_cpld_req_vld & o_cpld_req_rdy;
    assign ur       = (i_mrd_length == 10'd0)
                    | (i_mrd_length > 10'(MAX_CPL_DW));
    // 1 + ceil((len-1)/4); only evaluated for len <= 64
    assign nbeats   = 8'd1 + ((8'(i_mrd_length[6:0]) + 8'd2) >> 2);

    ipsl_pcie_dma_cpld_realign #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_realign (
        .clk              (clk),
        .rst              (rst),
        .start            (req_fire & ~ur),
        .start_line       (i_mrd_addr[ADDR_WIDTH+3:4]),
        .start_off        (i_mrd_addr[3:2]),
        .start_lines      (nbeats),
        .o_bar0_rd_clk_en (o_bar0_rd_clk_en),
        .o_bar0_rd_addr   (o_bar0_rd_addr),
        .i_bar0_rd_data   (i_bar0_rd_data),
        .out_vld          (line_vld),
        .out_rdy          (line_rdy),
        .out_data         (line_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tc_q    <= '0;
            attr_q  <= '0;
            len_q   <= '0;
            rid_q   <= '0;
            tag_q   <= '0;
            cid_q   <= '0;
            la_q    <= '0;
            ur_q    <= 1'b0;
            beats_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        tc_q    <= i_mrd_tc;
                        attr_q  <= i_mrd_attr;
                        len_q   <= i_mrd_length;
                        rid_q   <= i_mrd_id;
                        tag_q   <= i_mrd_tag;
                        cid_q   <= i_cfg_cmplt_id;
                        la_q    <= i_mrd_addr[6:2];
                        ur_q    <= ur;
                        beats_q <= ur ? 8'd1 : nbeats;
                        state   <= ur ? ST_HDR : ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_HDR;
                ST_HDR, ST_DATA: begin
                    if (beat_fire) begin
                        beats_q <= beats_q - 8'd1;
                        state   <= is_last ? ST_IDLE : ST_DATA;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cpld_req_rdy = (state == ST_IDLE);
    assign o_cpld_tx_rdy  = (state == ST_IDLE);

    assign active    = (state == ST_HDR) | (state == ST_DATA);
    assign is_last   = (beats_q == 8'd1);
    assign line_rdy  = active & ~ur_q & axis_slave.trdy;
    assign beat_fire = axis_slave.tvld & axis_slave.trdy;

    assign dw0 = {ur_q ? FMT_3DW_NODATA : FMT_3DW_DATA, TYPE_CPL,
                  1'b0, tc_q, 1'b0, attr_q[2], 4'b0000,
                  attr_q[1:0], 2'b00, ur_q ? 10'd0 : len_q};
    assign dw1 = {cid_q, ur_q ? CPL_UR : CPL_SC, 1'b0,
                  ur_q ? 12'd4 : {len_q, 2'b00}};
    assign dw2 = {rid_q, tag_q, 1'b0, la_q, 2'b00};

    always_comb begin
        tdata = '0;
        if (state == ST_HDR)
            tdata = {ur_q ? 32'd0 : line_data[127:96], dw2, dw1, dw0};
        else if (state == ST_DATA)
            tdata = line_data;
    end

    assign axis_slave.tvld  = active & (ur_q | line_vld);
    assign axis_slave.tdata = tdata;
    assign axis_slave.tlast = active & is_last;
    assign axis_slave.tkeep = !active ? 4'b0000 :
                              ur_q    ? 4'b0111 :
                              is_last ? last_keep(len_q[1:0]) : 4'b1111;

endmodule

// File: tb/tb_ipsl_pcie_dma_cpld_tx_gen.sv
// Scoreboard bench for the CplD generator with a BAR0 RAM model.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_ipsl_pcie_dma_cpld_tx_gen;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  i_cfg_cmplt_id = 16'h0100;
    logic         i_cpld_req_vld = 1'b0;
    logic         o_cpld_req_rdy;
    logic         o_cpld_tx_rdy;
    logic [2:0]   i_mrd_tc = '0;
    logic [2:0]   i_mrd_attr = '0;
    logic [9:0]   i_mrd_length = '0;
    logic [15:0]  i_mrd_id = '0;
    logic [7:0]   i_mrd_tag = '0;
    logic [63:0]  i_mrd_addr = '0;
    logic         o_bar0_rd_clk_en;
    logic [8:0]   o_bar0_rd_addr;
    logic [127:0] i_bar0_rd_data = '0;

    ipsl_pcie_dma_cpld_tx_gen_if axis ();

    ipsl_pcie_dma_cpld_tx_gen #(
        .ADDR_WIDTH (9),
        .MAX_CPL_DW (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cfg_cmplt_id   (i_cfg_cmplt_id),
        .i_cpld_req_vld   (i_cpld_req_vld),
        .o_cpld_req_rdy   (o_cpld_req_rdy),
        .o_cpld_tx_rdy    (o_cpld_tx_rdy),
        .i_mrd_tc         (i_mrd_tc),
        .i_mrd_attr       (i_mrd_attr),
        .i_mrd_length     (i_mrd_length),
        .i_mrd_id         (i_mrd_id),
        .i_mrd_tag        (i_mrd_tag),
        .i_mrd_addr       (i_mrd_addr),
        .o_bar0_rd_clk_en (o_bar0_rd_clk_en),
        .o_bar0_rd_addr   (o_bar0_rd_addr),
        .i_bar0_rd_data   (i_bar0_rd_data),
        .axis_slave       (axis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flat(input int j);
        return 32'h5A000000 + 32'(j % 2048);
    endfunction

    logic [127:0] mem [512];
    int rd_cnt = 0;

    initial begin
        for (int l = 0; l < 512; l++)
            for (int d = 0; d < 4; d++)
                mem[l][32*d +: 32] = flat(l * 4 + d);
    end

    always @(posedge clk) begin
        if (o_bar0_rd_clk_en) begin
            i_bar0_rd_data <= mem[o_bar0_rd_addr];
            rd_cnt <= rd_cnt + 1;
        end
    end

    int trdy_mode = 0;
    initial begin
        axis.trdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis.trdy = (trdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    beat_t sb[$];
    int vectors = 0;
    int errors = 0;
    int beats_seen = 0;

    function automatic logic [127:0] kmask(input logic [3:0] k);
        logic [127:0] m;
        for (int i = 0; i < 4; i++)
            m[32*i +: 32] = k[i] ? 32'hFFFFFFFF : 32'h0;
        return m;
    endfunction

    logic  stall_q = 1'b0;
    beat_t held;
    beat_t exp_b;
    logic [127:0] m;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                vectors++;
                if (!axis.tvld || axis.tdata !== held.d ||
                    axis.tkeep !== held.k || axis.tlast !== held.l) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%b d=%h k=%b l=%b required d=%h k=%b l=%b",
                             axis.tvld, axis.tdata, axis.tkeep, axis.tlast,
                             held.d, held.k, held.l);
                end
            end
            if (axis.tvld && axis.trdy) begin
                beats_seen++;
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h k=%b l=%b required none",
                             axis.tdata, axis.tkeep, axis.tlast);
                end else begin
                    exp_b = sb.pop_front();
                    m = kmask(exp_b.k);
                    if ((axis.tdata & m) !== (exp_b.d & m) ||
                        axis.tkeep !== exp_b.k || axis.tlast !== exp_b.l) begin
                        errors++;
                        $display("FAIL beat: got d=%h k=%b l=%b required d=%h k=%b l=%b",
                                 axis.tdata, axis.tkeep, axis.tlast,
                                 exp_b.d, exp_b.k, exp_b.l);
                    end
                end
            end
            stall_q = axis.tvld && !axis.trdy;
            held = {axis.tdata, axis.tkeep, axis.tlast};
        end
    end

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] req);
        vectors++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push_beat(input logic [127:0] d, input logic [3:0] k,
                             input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        sb.push_back(b);
    endtask

    task automatic exp_cpld(input int len, input logic [63:0] addr,
                            input logic [2:0] tc, input logic [2:0] attr,
                            input logic [15:0] rid, input logic [7:0] tag);
        logic [31:0]  h [3];
        logic [127:0] d;
        logic [3:0]   lk;
        int s, nb, r, k;
        s  = int'(addr[12:2]);
        nb = 1 + (len + 2) / 4;
        r  = (len - 1) % 4;
        lk = (r == 0) ? 4'b1111 : (r == 1) ? 4'b0001 :
             (r == 2) ? 4'b0011 : 4'b0111;
        h[0] = {3'b010, 5'b01010, 1'b0, tc, 1'b0, attr[2], 4'b0000,
                attr[1:0], 2'b00, 10'(len)};
        h[1] = {i_cfg_cmplt_id, 3'b000, 1'b0, 12'(len * 4)};
        h[2] = {rid, tag, 1'b0, addr[6:2], 2'b00};
        for (int n = 0; n < nb; n++) begin
            for (int i = 0; i < 4; i++) begin
                k = 4 * n - 3 + i;
                if (n == 0 && i < 3) d[32*i +: 32] = h[i];
                else                 d[32*i +: 32] = flat(s + k);
            end
            push_beat(d, (n == nb - 1) ? lk : 4'b1111, n == nb - 1);
        end
    endtask

    task automatic send_req(input logic [9:0] len, input logic [63:0] addr,
                            input logic [2:0] tc, input logic [2:0] attr,
                            input logic [15:0] rid, input logic [7:0] tag);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!o_cpld_req_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy_wait", 128'(o_cpld_req_rdy), 128'd1);
        i_cpld_req_vld = 1'b1;
        i_mrd_length   = len;
        i_mrd_addr     = addr;
        i_mrd_tc       = tc;
        i_mrd_attr     = attr;
        i_mrd_id       = rid;
        i_mrd_tag      = tag;
        @(posedge clk);
        #1;
        i_cpld_req_vld = 1'b0;
        lat = 0;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
            if (axis.tvld) break;
        end
        check("first_beat_latency", 128'(lat <= 3), 128'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(sb.size()), 128'd0);
        @(negedge clk);
    endtask

    int rd0;
    int base;
    int n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 128'(o_cpld_req_rdy), 128'd1);
        check("rst_tx_rdy", 128'(o_cpld_tx_rdy), 128'd1);
        check("rst_tvld", 128'(axis.tvld), 128'd0);
        check("rst_tkeep", 128'(axis.tkeep), 128'd0);
        check("rst_tlast", 128'(axis.tlast), 128'd0);
        check("rst_tdata", axis.tdata, 128'd0);
        check("rst_rd_en", 128'(o_bar0_rd_clk_en), 128'd0);
        check("rst_rd_addr", 128'(o_bar0_rd_addr), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single-beat CplD, hand-computed header
        push_beat({flat(4), 32'h02000510, 32'h01000004, 32'h4A000001},
                  4'b1111, 1'b1);
        send_req(10'd1, 64'h10, 3'd0, 3'd0, 16'h0200, 8'h05);
        drain("drain_len1");

        // len 8 at DW offset 3: lines 0,1,2
        rd0 = rd_cnt;
        exp_cpld(8, 64'h0C, 3'd2, 3'b101, 16'h0200, 8'h06);
        send_req(10'd8, 64'h0C, 3'd2, 3'b101, 16'h0200, 8'h06);
        drain("drain_len8");
        check("len8_reads", 128'(rd_cnt - rd0), 128'd3);

        // len 32 with random backpressure
        trdy_mode = 1;
        exp_cpld(32, 64'h04, 3'd7, 3'b111, 16'h1234, 8'hA5);
        send_req(10'd32, 64'h04, 3'd7, 3'b111, 16'h1234, 8'hA5);
        drain("drain_len32");
        trdy_mode = 0;

        // unsupported requests: too long, and length 0
        rd0 = rd_cnt;
        push_beat({32'h0, 32'h03002240, 32'h01002004, 32'h0A000000},
                  4'b0111, 1'b1);
        send_req(10'd64, 64'h40, 3'd0, 3'd0, 16'h0300, 8'h22);
        drain("drain_ur64");
        push_beat({32'h0, 32'h03002344, 32'h01002004, 32'h0A000000},
                  4'b0111, 1'b1);
        send_req(10'd0, 64'h44, 3'd0, 3'd0, 16'h0300, 8'h23);
        drain("drain_ur0");
        check("ur_no_reads", 128'(rd_cnt - rd0), 128'd0);

        // last RAM line, wraps to line 0; high address bits ignored
        exp_cpld(6, 64'hFFFF_0000_0000_1FF8, 3'd1, 3'b010, 16'h4321, 8'h7E);
        send_req(10'd6, 64'hFFFF_0000_0000_1FF8, 3'd1, 3'b010,
                 16'h4321, 8'h7E);
        drain("drain_wrap");

        // reset in the middle of a 9-beat TLP
        exp_cpld(32, 64'h20, 3'd0, 3'd0, 16'h0555, 8'h11);
        base = beats_seen;
        send_req(10'd32, 64'h20, 3'd0, 3'd0, 16'h0555, 8'h11);
        n = 0;
        while (beats_seen < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat2", 128'(beats_seen >= base + 2), 128'd1);
        check("mid_tvld", 128'(axis.tvld), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_tvld", 128'(axis.tvld), 128'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", 128'(o_cpld_req_rdy), 128'd1);
        check("post_rst_tx_rdy", 128'(o_cpld_tx_rdy), 128'd1);

        // clean TLP after reset, with backpressure
        trdy_mode = 1;
        exp_cpld(5, 64'h30, 3'd3, 3'b001, 16'h0777, 8'h42);
        send_req(10'd5, 64'h30, 3'd3, 3'b001, 16'h0777, 8'h42);
        drain("drain_post_rst");
        trdy_mode = 0;

        // back-to-back requests
        exp_cpld(3, 64'h104, 3'd0, 3'd0, 16'h0888, 8'h01);
        exp_cpld(12, 64'h208, 3'd0, 3'd0, 16'h0888, 8'h02);
        send_req(10'd3, 64'h104, 3'd0, 3'd0, 16'h0888, 8'h01);
        send_req(10'd12, 64'h208, 3'd0, 3'd0, 16'h0888, 8'h02);
        drain("drain_b2b");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
